// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler: time-multiplexed scan controller for an
// 8-digit (parameterisable) dynamic 7-segment display.
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   en_i           scan enable; low parks the scan in GUARD at digit 0
//   wr_valid_i     shadow write request
//   wr_ready_o     shadow write can be accepted (low while commit pending)
//   wr_idx_i       target digit of the write
//   wr_data_i      {blank, dp, hex[3:0]}
//   commit_i       pulse: copy shadow to active at next frame boundary
//   commit_done_o  pulse on the cycle the copy happens
//   frame_done_o   pulse on the first GUARD cycle after the last digit
//   abcdefgh_o     segments, active-high, bit7=a .. bit1=g, bit0=dp
//   digit_o        one-hot digit select, active-high, bit0 rightmost

module seg7_scan_scheduler #(
   parameter int w_digit      = 8,
   parameter int drive_cycles = 45000,
   parameter int guard_cycles = 5000,
   localparam int IW   = (w_digit > 1) ? $clog2(w_digit) : 1,
   localparam int MAXC = (drive_cycles > guard_cycles) ?
                         drive_cycles : guard_cycles,
   localparam int CW   = $clog2(MAXC + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               wr_valid_i,
   output logic               wr_ready_o,
   input  logic [IW-1:0]      wr_idx_i,
   input  logic [5:0]         wr_data_i,
   input  logic               commit_i,
   output logic               commit_done_o,
   output logic               frame_done_o,
   output logic [7:0]         abcdefgh_o,
   output logic [w_digit-1:0] digit_o
);

   typedef enum logic {
      GUARD = 1'b0,
      DRIVE = 1'b1
   } state_e;

   localparam logic [CW-1:0] GUARD_LAST = CW'(guard_cycles - 1);
   localparam logic [CW-1:0] DRIVE_LAST = CW'(drive_cycles - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(w_digit - 1);
   localparam logic [5:0]    BLANK      = 6'b100000;

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [IW-1:0]            idx_q, idx_d;
   logic                     pending_q, pending_d;
   logic [w_digit-1:0][5:0]  shadow_q, shadow_d;
   logic [w_digit-1:0][5:0]  active_q, active_d;
   logic [7:0]               seg_q, seg_d;
   logic [w_digit-1:0]       dig_q, dig_d;
   logic                     fd_q, fd_d;
   logic                     cd_q, cd_d;
   logic                     wr_fire;

   function automatic logic [6:0] hex7seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      return s;
   endfunction

   function automatic logic [7:0] seg(input logic [5:0] e);
      logic [7:0] s;
      if (e[5]) s = 8'h00;
      else      s = {hex7seg(e[3:0]), e[4]};
      return s;
   endfunction

   // Ready is combinational on rst so it is low for exactly the
   // cycles reset is asserted.
   assign wr_ready_o = !rst_i && !pending_q;
   assign wr_fire    = wr_valid_i && wr_ready_o;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      fd_d      = 1'b0;
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      dig_d     = '0;
      seg_d     = 8'h00;

      if (!en_i) begin
         state_d = GUARD;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            GUARD: begin
               if (cnt_q == GUARD_LAST) begin
                  state_d = DRIVE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            DRIVE: begin
               if (cnt_q == DRIVE_LAST) begin
                  state_d = GUARD;
                  cnt_d   = '0;
                  if (idx_q == IDX_LAST) begin
                     idx_d = '0;
                     fd_d  = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         endcase
      end

      // Out-of-range indices match no entry and are dropped.
      for (int i = 0; i < w_digit; i++) begin
         if (wr_fire && wr_idx_i == IW'(i)) shadow_d[i] = wr_data_i;
      end

      // cd_q marks the copy cycle; pending is still set during it,
      // so no write can race the copy.
      if (cd_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end else if (commit_i) begin
         pending_d = 1'b1;
      end

      cd_d = pending_d && (fd_d || !en_i);

      // Segments use next-cycle active so a copy followed by an
      // immediate DRIVE (guard of one clock) shows the new value.
      if (state_d == DRIVE) begin
         dig_d[idx_d] = 1'b1;
         seg_d        = seg(active_d[idx_d]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= GUARD;
         cnt_q     <= '0;
         idx_q     <= '0;
         pending_q <= 1'b0;
         shadow_q  <= {w_digit{BLANK}};
         active_q  <= {w_digit{BLANK}};
         seg_q     <= 8'h00;
         dig_q     <= '0;
         fd_q      <= 1'b0;
         cd_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         seg_q     <= seg_d;
         dig_q     <= dig_d;
         fd_q      <= fd_d;
         cd_q      <= cd_d;
      end
   end

   assign abcdefgh_o    = seg_q;
   assign digit_o       = dig_q;
   assign frame_done_o  = fd_q;
   assign commit_done_o = cd_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb_seg7_scan_scheduler: randomized self-checking bench for
// seg7_scan_scheduler against a time-position reference model.

module tb_seg7_scan_scheduler;

   localparam int W     = 4;
   localparam int DRV   = 4;
   localparam int GRD   = 2;
   localparam int SLOT  = GRD + DRV;
   localparam int FRAME = W * SLOT;

   logic       clk = 1'b0;
   logic       rst, en, wr_valid, wr_ready, commit;
   logic       commit_done, frame_done;
   logic [1:0] wr_idx;
   logic [5:0] wr_data;
   logic [7:0] abcdefgh;
   logic [3:0] digit;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seg7_scan_scheduler #(
      .w_digit(W),
      .drive_cycles(DRV),
      .guard_cycles(GRD)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .en_i(en),
      .wr_valid_i(wr_valid),
      .wr_ready_o(wr_ready),
      .wr_idx_i(wr_idx),
      .wr_data_i(wr_data),
      .commit_i(commit),
      .commit_done_o(commit_done),
      .frame_done_o(frame_done),
      .abcdefgh_o(abcdefgh),
      .digit_o(digit)
   );

   // Reference model: scan position in clocks since the first GUARD
   // cycle; everything displayed is derived arithmetically from it.
   logic [5:0] m_shadow [W];
   logic [5:0] m_active [W];
   bit         m_pending;
   bit         m_cd;
   int         m_t;

   logic [6:0] hex_tab [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   function automatic logic [7:0] segf(input logic [5:0] e);
      if (e[5]) return 8'h00;
      return {hex_tab[e[3:0]], e[4]};
   endfunction

   function automatic logic [14:0] expv();
      int p, slot;
      logic [3:0] d;
      logic [7:0] s;
      p    = m_t % FRAME;
      slot = p / SLOT;
      d    = 4'h0;
      s    = 8'h00;
      if ((p % SLOT) >= GRD) begin
         d = 4'(1 << slot);
         s = segf(m_active[slot]);
      end
      return {d, s, (m_t > 0 && p == 0), m_cd, (!rst && !m_pending)};
   endfunction

   function automatic logic [14:0] obsv();
      return {digit, abcdefgh, frame_done, commit_done, wr_ready};
   endfunction

   task automatic model_step();
      if (rst) begin
         m_t = 0;
         m_pending = 0;
         m_cd = 0;
         for (int i = 0; i < W; i++) begin
            m_shadow[i] = 6'h20;
            m_active[i] = 6'h20;
         end
      end else begin
         if (wr_valid && !m_pending) m_shadow[wr_idx] = wr_data;
         if (m_cd) begin
            for (int i = 0; i < W; i++) m_active[i] = m_shadow[i];
            m_pending = 0;
         end else if (commit) begin
            m_pending = 1;
         end
         m_t  = en ? m_t + 1 : 0;
         m_cd = m_pending && (!en || (m_t % FRAME == 0));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) begin
         tick();
         total++;
         if (obsv() !== 15'h0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0000", obsv());
         end
      end
      rst = 0;
      #1;
      total++;
      if (wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: got %b want 1", wr_ready);
      end
   endtask

   task automatic test_scan_order();
      logic [3:0] seq [12] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1,
                               4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2};
      int nfd = 0;
      for (int i = 0; i < 12; i++) begin
         total++;
         if (digit !== seq[i]) begin
            bad++;
            $display("FAIL scan_seq[%0d]: got %h want %h", i, digit, seq[i]);
         end
         tick();
      end
      for (int c = 0; c < 60; c++) begin
         total++;
         if (obsv() !== expv()) begin
            bad++;
            $display("FAIL scan_model t=%0d: got %h want %h",
                     m_t, obsv(), expv());
         end
         if (frame_done === 1'b1) nfd++;
         tick();
      end
      total++;
      if (frame_done === 1'b1) nfd++;
      if (nfd != 3) begin
         bad++;
         $display("FAIL scan_frame_done_count: got %0d want 3", nfd);
      end
   endtask

   task automatic test_commit();
      bit seen;
      wr_valid = 1; wr_idx = 0; wr_data = 6'h05; tick();
      wr_idx = 1; wr_data = 6'h1A; tick();
      wr_valid = 0; commit = 1; tick();
      commit = 0;
      total++;
      if (wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL commit_ready_drop: got %b want 0", wr_ready);
      end
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
         total++;
         if (obsv() !== expv()) begin
            bad++;
            $display("FAIL commit_model t=%0d: got %h want %h",
                     m_t, obsv(), expv());
         end
         if (commit_done === 1'b1) begin
            seen = 1;
            total++;
            if (frame_done !== 1'b1) begin
               bad++;
               $display("FAIL commit_fd_align: got %b want 1", frame_done);
            end
         end else begin
            tick();
         end
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL commit_timeout: got none want commit_done");
      end
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
         tick();
         if (digit === 4'b0001) seen = 1;
      end
      total++;
      if (!seen || abcdefgh !== 8'hB6) begin
         bad++;
         $display("FAIL commit_digit0: got %h want b6", abcdefgh);
      end
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
         tick();
         if (digit === 4'b0010) seen = 1;
      end
      total++;
      if (!seen || abcdefgh !== 8'hEF) begin
         bad++;
         $display("FAIL commit_digit1: got %h want ef", abcdefgh);
      end
   endtask

   task automatic test_write_blocked();
      logic [5:0] d1, d2;
      bit seen;
      d1 = {1'b0, 1'($urandom), 4'($urandom)};
      d2 = d1 ^ 6'h0F;
      wr_valid = 1; wr_idx = 2; wr_data = d1; tick();
      wr_valid = 0; commit = 1; tick();
      commit = 0; wr_valid = 1; wr_data = d2;
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
         total++;
         if (obsv() !== expv()) begin
            bad++;
            $display("FAIL blocked_model t=%0d: got %h want %h",
                     m_t, obsv(), expv());
         end
         if (commit_done === 1'b1) seen = 1;
         else tick();
      end
      tick();
      total++;
      if (!seen || wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL blocked_ready_after: got %b want 1", wr_ready);
      end
      tick();
      wr_valid = 0;
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
         tick();
         if (digit === 4'b0100) seen = 1;
      end
      total++;
      if (!seen || abcdefgh !== segf(d1)) begin
         bad++;
         $display("FAIL blocked_shadow: got %h want %h", abcdefgh, segf(d1));
      end
   endtask

   task automatic test_commit_on_fd();
      bit seen;
      int n;
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
         tick();
         if (frame_done === 1'b1) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL defer_no_fd: got none want frame_done");
      end
      commit = 1; tick();
      commit = 0;
      n = 1;
      seen = 0;
      for (int c = 0; c < 3 * FRAME && !seen; c++) begin
         total++;
         if (obsv() !== expv()) begin
            bad++;
            $display("FAIL defer_model t=%0d: got %h want %h",
                     m_t, obsv(), expv());
         end
         if (commit_done === 1'b1) seen = 1;
         else begin
            tick();
            n++;
         end
      end
      total++;
      if (!seen || n != FRAME) begin
         bad++;
         $display("FAIL defer_latency: got %0d want %0d", n, FRAME);
      end
   endtask

   task automatic test_en_low();
      bit seen;
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
         tick();
         if (digit === 4'b0100) seen = 1;
      end
      commit = 1; tick();
      commit = 0;
      total++;
      if (digit !== 4'b0100 || wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL enlow_setup: got %h/%b want 4/0", digit, wr_ready);
      end
      en = 0; tick();
      total++;
      if (obsv() !== 15'b0000_00000000_0_1_0) begin
         bad++;
         $display("FAIL enlow_off: got %h want 0002", obsv());
      end
      en = 1; tick();
      total++;
      if (digit !== 4'h0 || wr_ready !== 1'b1 || obsv() !== expv()) begin
         bad++;
         $display("FAIL enlow_guard: got %h want %h", obsv(), expv());
      end
      tick();
      total++;
      if (digit !== 4'b0001) begin
         bad++;
         $display("FAIL enlow_restart: got %h want 1", digit);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int ncd = 0;
      int nseg = 0;
      seen = 0;
      for (int c = 0; c < 2 * FRAME && !seen; c++) begin
         tick();
         if (digit !== 4'h0) seen = 1;
      end
      commit = 1; tick();
      commit = 0;
      rst = 1; tick();
      total++;
      if (obsv() !== 15'h0) begin
         bad++;
         $display("FAIL rstmid_outputs: got %h want 0000", obsv());
      end
      tick();
      rst = 0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         tick();
         total++;
         if (obsv() !== expv()) begin
            bad++;
            $display("FAIL rstmid_model t=%0d: got %h want %h",
                     m_t, obsv(), expv());
         end
         if (commit_done === 1'b1) ncd++;
         if (abcdefgh !== 8'h00) nseg++;
      end
      total++;
      if (ncd != 0 || nseg != 0) begin
         bad++;
         $display("FAIL rstmid_blank: got cd=%0d seg=%0d want 0/0", ncd, nseg);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         wr_valid = 1'($urandom);
         wr_idx   = 2'($urandom);
         wr_data  = 6'($urandom);
         commit   = ($urandom_range(0, 15) == 0);
         en       = ($urandom_range(0, 39) != 0);
         tick();
         total++;
         if (obsv() !== expv()) begin
            bad++;
            $display("FAIL random t=%0d: got %h want %h", m_t, obsv(), expv());
         end
      end
      wr_valid = 0;
      commit   = 0;
      en       = 1;
   endtask

   initial begin
      rst      = 1;
      en       = 1;
      wr_valid = 0;
      wr_idx   = 0;
      wr_data  = 0;
      commit   = 0;
      test_reset();
      test_scan_order();
      test_commit();
      test_write_blocked();
      test_commit_on_fd();
      test_en_low();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
